// File: rtl/req_rsp_mux_loopback.sv
// Request/response mux with loopback.
// Each request channel feeds its own FIFO. A round-robin arbiter pops one
// FIFO at a time into a single output register, which returns the data
// (optionally transformed) along with the index of the channel it came from.
module req_rsp_mux_loopback #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int CHANNELS = 2,
    parameter int MODE     = 0,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PW      = $clog2(DEPTH),
    localparam int OW      = PW + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       req_valid,
    output logic [CHANNELS-1:0]       req_ready,
    input  logic [CHANNELS*WIDTH-1:0] req_data,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_data,
    output logic [CW-1:0]             rsp_chan,
    output logic [CHANNELS*OW-1:0]    occupancy
);

    logic [WIDTH-1:0]    mem    [CHANNELS][DEPTH];
    logic [PW-1:0]       wr_ptr [CHANNELS];
    logic [PW-1:0]       rd_ptr [CHANNELS];
    logic [OW-1:0]       count  [CHANNELS];
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] nonempty;
    logic [CW-1:0]       last_grant;
    logic [CW-1:0]       grant;
    logic                found;
    logic                load;
    logic [WIDTH-1:0]    head_data;
    logic [WIDTH-1:0]    xform_data;

    // Per-channel flags; ready is held low while reset is asserted and only looks at the fill count.
    always_comb begin
        req_ready = '0;
        nonempty  = '0;
        push      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            nonempty[i]  = (count[i] != '0);
            req_ready[i] = reset && (count[i] != OW'(DEPTH));
            push[i]      = req_valid[i] && req_ready[i];
        end
    end

    // Round-robin search starting one past the last granted channel; the first non-empty channel wins.
    always_comb begin
        int            cand;
        logic [CW-1:0] cidx;
        cand  = 0;
        cidx  = '0;
        found = 1'b0;
        grant = last_grant;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            cidx = CW'(cand);
            if (!found && nonempty[cidx]) begin
                found = 1'b1;
                grant = cidx;
            end
        end
    end

    // Output register loads when it is empty or being consumed and some FIFO has data; that load pops the granted FIFO.
    always_comb begin
        load = (!rsp_valid || rsp_ready) && found;
        pop  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pop[i] = load && (grant == CW'(i));
        end
        head_data = mem[grant][rd_ptr[grant]];
        if (MODE == 1) begin
            xform_data = head_data + WIDTH'(1);
        end else if (MODE == 2) begin
            xform_data = ~head_data;
        end else begin
            xform_data = head_data;
        end
    end

    // FIFO pointers and fill counts; a push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                count[i] <= count[i] + OW'(push[i]) - OW'(pop[i]);
            end
        end
    end

    // FIFO storage writes; no reset needed since pushes are blocked during reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output register and arbiter history; data and channel hold their last values when valid drops.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_chan   <= '0;
            last_grant <= CW'(CHANNELS - 1);
        end else if (load) begin
            rsp_valid  <= 1'b1;
            rsp_data   <= xform_data;
            rsp_chan   <= grant;
            last_grant <= grant;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    // Expose raw fill counts with no output register.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            occupancy[i*OW +: OW] = count[i];
        end
    end

endmodule

// File: tb/tb_req_rsp_mux_loopback.sv
// Testbench for req_rsp_mux_loopback: directed scenarios plus randomized
// traffic, checked every cycle against a queue-based reference model.
module tb_req_rsp_mux_loopback;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_chan;
    logic [5:0]  occupancy;

    logic [1:0]  m_req_valid;
    logic        m_rsp_ready;
    logic [15:0] m1_req_data;
    logic [15:0] m2_req_data;
    logic [1:0]  m1_req_ready;
    logic [1:0]  m2_req_ready;
    logic        m1_rsp_valid;
    logic        m2_rsp_valid;
    logic [7:0]  m1_rsp_data;
    logic [7:0]  m2_rsp_data;
    logic        m1_rsp_chan;
    logic        m2_rsp_chan;
    logic [5:0]  m1_occupancy;
    logic [5:0]  m2_occupancy;

    // Reference model state: one queue per channel plus the output register contents.
    logic [31:0] mq [2][$];
    logic        mvalid = 1'b0;
    logic [31:0] mdata  = 32'h0;
    int          mchan  = 0;
    int          mlast  = 1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    req_rsp_mux_loopback #(.WIDTH(32), .DEPTH(4), .CHANNELS(2), .MODE(0)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_chan(rsp_chan), .occupancy(occupancy)
    );

    req_rsp_mux_loopback #(.WIDTH(8), .DEPTH(4), .CHANNELS(2), .MODE(1)) dut_m1 (
        .clock(clock), .reset(reset),
        .req_valid(m_req_valid), .req_ready(m1_req_ready), .req_data(m1_req_data),
        .rsp_valid(m1_rsp_valid), .rsp_ready(m_rsp_ready), .rsp_data(m1_rsp_data),
        .rsp_chan(m1_rsp_chan), .occupancy(m1_occupancy)
    );

    req_rsp_mux_loopback #(.WIDTH(8), .DEPTH(4), .CHANNELS(2), .MODE(2)) dut_m2 (
        .clock(clock), .reset(reset),
        .req_valid(m_req_valid), .req_ready(m2_req_ready), .req_data(m2_req_data),
        .rsp_valid(m2_rsp_valid), .rsp_ready(m_rsp_ready), .rsp_data(m2_rsp_data),
        .rsp_chan(m2_rsp_chan), .occupancy(m2_occupancy)
    );

    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic checkOutput();
        checkVal("rsp_valid", 64'(rsp_valid), 64'(mvalid));
        checkVal("rsp_data", 64'(rsp_data), 64'(mdata));
        checkVal("rsp_chan", 64'(rsp_chan), 64'(mchan));
        for (int i = 0; i < 2; i++) begin
            checkVal("req_ready", 64'(req_ready[i]), 64'(reset && (mq[i].size() < 4)));
            checkVal("occupancy", 64'(occupancy[i*3 +: 3]), 64'(mq[i].size()));
        end
    endtask

    // Drive one cycle of inputs, advance the model over the edge, then check.
    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                                 input logic rr, input logic rst);
        bit [1:0] rdy;
        int       c;
        req_valid = v;
        req_data  = {d1, d0};
        rsp_ready = rr;
        reset     = rst;
        @(posedge clock);
        #1;
        if (!rst) begin
            mq[0].delete();
            mq[1].delete();
            mvalid = 1'b0;
            mdata  = 32'h0;
            mchan  = 0;
            mlast  = 1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                rdy[i] = (mq[i].size() < 4);
            end
            if ((!mvalid || rr) && (mq[0].size() > 0 || mq[1].size() > 0)) begin
                c = (mlast + 1) % 2;
                if (mq[c].size() == 0) begin
                    c = (c + 1) % 2;
                end
                mdata  = mq[c].pop_front();
                mchan  = c;
                mlast  = c;
                mvalid = 1'b1;
            end else if (rr) begin
                mvalid = 1'b0;
            end
            if (v[0] && rdy[0]) mq[0].push_back(d0);
            if (v[1] && rdy[1]) mq[1].push_back(d1);
        end
        checkOutput();
    endtask

    task automatic doReset();
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [31:0] exp_d;
        req_valid   = 2'b00;
        req_data    = 64'h0;
        rsp_ready   = 1'b0;
        reset       = 1'b0;
        m_req_valid = 2'b00;
        m_rsp_ready = 1'b1;
        m1_req_data = 16'h0;
        m2_req_data = 16'h0;

        $display("[TB] reset");
        repeat (3) applyStimulus(2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
        checkVal("reset_valid", 64'(rsp_valid), 64'h0);
        checkVal("reset_occ", 64'(occupancy), 64'h0);
        checkVal("reset_ready", 64'(req_ready), 64'h0);
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
        checkVal("ready_after_release", 64'(req_ready), 64'h3);

        $display("[TB] single beat");
        applyStimulus(2'b01, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1);
        checkVal("beat_latency", 64'(rsp_valid), 64'h0);
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
        checkVal("beat_valid", 64'(rsp_valid), 64'h1);
        checkVal("beat_data", 64'(rsp_data), 64'hDEADBEEF);
        checkVal("beat_chan", 64'(rsp_chan), 64'h0);
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
        checkVal("beat_drop", 64'(rsp_valid), 64'h0);
        checkVal("beat_hold", 64'(rsp_data), 64'hDEADBEEF);

        $display("[TB] fairness");
        doReset();
        for (int k = 0; k < 9; k++) begin
            applyStimulus((k < 4) ? 2'b11 : 2'b00, 32'hA000 + 32'(k), 32'hB000 + 32'(k), 1'b1, 1'b1);
            if (k >= 1) begin
                exp_d = ((k - 1) % 2 == 0) ? 32'hA000 + 32'((k - 1) / 2) : 32'hB000 + 32'((k - 1) / 2);
                checkVal("fair_valid", 64'(rsp_valid), 64'h1);
                checkVal("fair_chan", 64'(rsp_chan), 64'((k - 1) % 2));
                checkVal("fair_data", 64'(rsp_data), 64'(exp_d));
            end
        end

        $display("[TB] full and backpressure");
        doReset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2'b01, 32'hC000 + 32'(k), 32'h0, 1'b0, 1'b1);
        end
        checkVal("full_ready", 64'(req_ready[0]), 64'h0);
        checkVal("full_occ", 64'(occupancy[2:0]), 64'h4);
        checkVal("full_hold", 64'(rsp_data), 64'hC000);
        applyStimulus(2'b01, 32'hC005, 32'h0, 1'b1, 1'b1);
        checkVal("full_reject_occ", 64'(occupancy[2:0]), 64'h3);
        checkVal("full_rel_data", 64'(rsp_data), 64'hC001);
        applyStimulus(2'b01, 32'hC005, 32'h0, 1'b1, 1'b1);
        checkVal("full_accept_occ", 64'(occupancy[2:0]), 64'h3);
        checkVal("full_order2", 64'(rsp_data), 64'hC002);
        for (int j = 0; j < 3; j++) begin
            applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
            checkVal("full_order", 64'(rsp_data), 64'(32'hC003 + 32'(j)));
        end
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
        checkVal("full_drained", 64'(rsp_valid), 64'h0);

        $display("[TB] simultaneous push/pop");
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b10, 32'h0, 32'hD000 + 32'(k), 1'b0, 1'b1);
        end
        checkVal("sim_pre_occ", 64'(occupancy[5:3]), 64'h2);
        applyStimulus(2'b10, 32'h0, 32'hD003, 1'b1, 1'b1);
        checkVal("sim_pushpop_occ", 64'(occupancy[5:3]), 64'h2);
        checkVal("sim_pushpop_data", 64'(rsp_data), 64'hD001);

        $display("[TB] reset mid-traffic");
        applyStimulus(2'b10, 32'h0, 32'hD004, 1'b0, 1'b1);
        checkVal("mid_occ", 64'(occupancy[5:3]), 64'h3);
        applyStimulus(2'b11, 32'hEEEE, 32'hEEEE, 1'b1, 1'b0);
        checkVal("mid_reset_valid", 64'(rsp_valid), 64'h0);
        checkVal("mid_reset_occ", 64'(occupancy), 64'h0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
            checkVal("no_stale", 64'(rsp_valid), 64'h0);
        end

        $display("[TB] transform modes");
        m1_req_data = 16'h00FF;
        m2_req_data = 16'h00A5;
        m_req_valid = 2'b01;
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
        m_req_valid = 2'b00;
        applyStimulus(2'b00, 32'h0, 32'h0, 1'b1, 1'b1);
        checkVal("mode1_valid", 64'(m1_rsp_valid), 64'h1);
        checkVal("mode1_data", 64'(m1_rsp_data), 64'h00);
        checkVal("mode2_valid", 64'(m2_rsp_valid), 64'h1);
        checkVal("mode2_data", 64'(m2_rsp_data), 64'h5A);

        $display("[TB] random traffic");
        for (int k = 0; k < 400; k++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0));
        end
        for (int k = 0; k < 200; k++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom, $urandom,
                          ($urandom_range(0, 3) == 0), 1'b1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
